pwm_fade_controller: RTL

//  Sequences the dutyCycle input of the PWM generator. Accepts fade commands
//  (target duty, step size, step interval) over a valid/ready handshake.

---
 rtl/pwm_fade_controller.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_controller.sv
// Fade sequencer for the PWM generator duty input: accepts a fade command and
// ramps the registered duty toward the target in bounded steps at a fixed interval.
module pwm_fade_controller #(
   parameter int N = 8,
   parameter int INTV_W = 16,
   parameter logic [N-1:0] INIT_DUTY = {N{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N-1:0]      targetDuty,
   input  logic [N-1:0]      stepSize,
   input  logic [INTV_W-1:0] stepInterval,
   input  logic              cmdValid,
   output logic              cmdReady,
   input  logic              abort,
   output logic [N-1:0]      dutyCycle,
   output logic              busy,
   output logic              done
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   state_t              state_r, state_s;
   logic [INTV_W-1:0]   timer_r, timer_s;
   logic [INTV_W-1:0]   intv_r, intv_s;
   logic [N-1:0]        duty_r, duty_s;
   logic [N-1:0]        tgt_r, tgt_s;
   logic [N-1:0]        step_r, step_s;
   logic                ready_r, ready_s;
   logic                busy_r, busy_s;
   logic                done_r, done_s;
   logic [INTV_W:0]     timer_inc_s;
   logic                tick_s;
   logic [N-1:0]        duty_next_s;

   function automatic logic [N-1:0] min_one_duty(input logic [N-1:0] v);
      if (v == {N{1'b0}}) begin
         return {{(N-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   function automatic logic [INTV_W-1:0] min_one_intv(input logic [INTV_W-1:0] v);
      if (v == {INTV_W{1'b0}}) begin
         return {{(INTV_W-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   // Done in N+1 bits so the step never overshoots the target nor wraps at 0 / 2^N-1.
   function automatic logic [N-1:0] step_toward(input logic [N-1:0] d,
                                                input logic [N-1:0] tgt,
                                                input logic [N-1:0] step);
      logic [N:0] gap;
      logic [N:0] res;
      if (tgt > d) begin
         gap = {1'b0, tgt} - {1'b0, d};
         if ({1'b0, step} >= gap) begin
            res = {1'b0, tgt};
         end else begin
            res = {1'b0, d} + {1'b0, step};
         end
      end else if (tgt < d) begin
         gap = {1'b0, d} - {1'b0, tgt};
         if ({1'b0, step} >= gap) begin
            res = {1'b0, tgt};
         end else begin
            res = {1'b0, d} - {1'b0, step};
         end
      end else begin
         gap = {(N+1){1'b0}};
         res = {1'b0, d};
      end
      return res[N-1:0];
   endfunction

   assign timer_inc_s = {1'b0, timer_r} + {{INTV_W{1'b0}}, 1'b1};
   assign tick_s      = (timer_inc_s == {1'b0, intv_r});
   assign duty_next_s = step_toward(duty_r, tgt_r, step_r);

   // Next-state and next-output logic for the IDLE/RAMP sequencer.
   always_comb begin
      state_s = state_r;
      timer_s = timer_r;
      intv_s  = intv_r;
      duty_s  = duty_r;
      tgt_s   = tgt_r;
      step_s  = step_r;
      ready_s = ready_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b1;
            busy_s  = 1'b0;
            if (cmdValid && ready_r) begin
               tgt_s   = targetDuty;
               step_s  = min_one_duty(stepSize);
               intv_s  = min_one_intv(stepInterval);
               timer_s = {INTV_W{1'b0}};
               if (targetDuty == duty_r) begin
                  done_s = 1'b1;
               end else begin
                  state_s = ST_RAMP;
                  ready_s = 1'b0;
                  busy_s  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RAMP: begin
            if (abort) begin
               state_s = ST_IDLE;
               timer_s = {INTV_W{1'b0}};
               ready_s = 1'b1;
               busy_s  = 1'b0;
            end else if (tick_s) begin
               duty_s  = duty_next_s;
               timer_s = {INTV_W{1'b0}};
               if (duty_next_s == tgt_r) begin
                  state_s = ST_IDLE;
                  ready_s = 1'b1;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_RAMP;
               end
            end else begin
               timer_s = timer_inc_s[INTV_W-1:0];
            end
         end
         default: begin
            state_s = ST_IDLE;
            timer_s = {INTV_W{1'b0}};
            ready_s = 1'b1;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         timer_r <= {INTV_W{1'b0}};
         intv_r  <= {INTV_W{1'b0}};
         duty_r  <= INIT_DUTY;
         tgt_r   <= {N{1'b0}};
         step_r  <= {N{1'b0}};
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         timer_r <= timer_s;
         intv_r  <= intv_s;
         duty_r  <= duty_s;
         tgt_r   <= tgt_s;
         step_r  <= step_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign dutyCycle = duty_r;
   assign cmdReady  = ready_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule
